// File: rtl/pac_mport.sv
// pac_mport: packet action controller between forwarding lookup and the
// buffer manager / output ports. It applies per-priority buffer admission
// on the queued path and forwards each packet once with a destination
// bitmap. It also builds TSN metadata for the queued copy and keeps
// per-port, drop and abort statistics.
module pac_mport #(
    parameter int DW    = 134,
    parameter int NPORT = 4,
    parameter int IDW   = 6,
    parameter int CNT_W = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DW-1:0]          in_data,
    input  logic                   in_data_wr,
    input  logic                   in_valid,
    input  logic                   in_valid_wr,
    input  logic [NPORT+2:0]       in_action,
    input  logic                   in_action_wr,
    input  logic [IDW-1:0]         bufm_id_count,
    input  logic [IDW-1:0]         cfg_th_hi,
    input  logic [IDW-1:0]         cfg_th_lo,
    output logic [DW-1:0]          out_data,
    output logic                   out_data_wr,
    output logic [NPORT-1:0]       out_port_mask,
    output logic                   out_valid,
    output logic                   out_valid_wr,
    output logic [23:0]            out_tsn_md,
    output logic                   out_tsn_md_wr,
    output logic [NPORT*CNT_W-1:0] port_pkt_cnt,
    output logic [CNT_W-1:0]       drop_cnt,
    output logic [CNT_W-1:0]       abort_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        FWD,
        DROP
    } state_t;

    state_t           state;
    logic [NPORT+2:0] act_q;
    logic [NPORT+2:0] cur_act;
    logic [2:0]       cur_prio;
    logic [NPORT-1:0] fin_mask;
    logic             refuse;
    logic             bufm_refused;
    logic             is_head;
    logic             is_tail;

    assign is_head = in_data_wr && (in_data[DW-1:DW-2] == 2'b01);
    assign is_tail = in_data_wr && (in_data[DW-1:DW-2] == 2'b10);

    // Effective action for a head beat and admission of the queued (bit 0) copy
    always_comb begin
        cur_act  = in_action_wr ? in_action : act_q;
        cur_prio = cur_act[NPORT+2:NPORT];
        refuse   = (bufm_id_count == '0)
                || ((bufm_id_count <= cfg_th_lo) && (cur_prio <= 3'd1))
                || ((bufm_id_count <= cfg_th_hi) && (cur_prio == 3'd0));
        fin_mask = cur_act[NPORT-1:0];
        if (refuse) begin
            fin_mask[0] = 1'b0;
        end
        bufm_refused = refuse && cur_act[0] && (fin_mask != '0);
    end

    // Packet state machine with registered beat, status, metadata and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            act_q         <= '0;
            out_data      <= '0;
            out_data_wr   <= 1'b0;
            out_port_mask <= '0;
            out_valid     <= 1'b0;
            out_valid_wr  <= 1'b0;
            out_tsn_md    <= '0;
            out_tsn_md_wr <= 1'b0;
            port_pkt_cnt  <= '0;
            drop_cnt      <= '0;
            abort_cnt     <= '0;
        end else begin
            out_data_wr   <= 1'b0;
            out_valid     <= 1'b0;
            out_valid_wr  <= 1'b0;
            out_tsn_md_wr <= 1'b0;

            if (in_action_wr) begin
                act_q <= in_action;
            end

            if (is_head) begin
                // A head inside an open packet truncates it; the close pulse
                // shares the output cycle with the new head beat.
                if (state == FWD) begin
                    out_valid_wr <= 1'b1;
                    out_valid    <= 1'b0;
                    abort_cnt    <= abort_cnt + CNT_W'(1);
                end else if (state == DROP) begin
                    abort_cnt    <= abort_cnt + CNT_W'(1);
                end

                if (fin_mask != '0) begin
                    state         <= FWD;
                    out_data      <= in_data;
                    out_data_wr   <= 1'b1;
                    out_port_mask <= fin_mask;
                    out_tsn_md    <= {cur_prio, in_data[107:96], fin_mask[0], 8'h00};
                    out_tsn_md_wr <= fin_mask[0];
                    if (bufm_refused) begin
                        drop_cnt <= drop_cnt + CNT_W'(1);
                    end
                end else begin
                    state    <= DROP;
                    drop_cnt <= drop_cnt + CNT_W'(1);
                end
            end else if (in_data_wr) begin
                case (state)
                    FWD: begin
                        out_data    <= in_data;
                        out_data_wr <= 1'b1;
                        if (is_tail) begin
                            state        <= IDLE;
                            out_valid_wr <= 1'b1;
                            out_valid    <= in_valid_wr ? in_valid : 1'b1;
                            for (int unsigned i = 0; i < NPORT; i++) begin
                                if (out_port_mask[i]) begin
                                    port_pkt_cnt[i*CNT_W +: CNT_W] <=
                                        port_pkt_cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
                                end
                            end
                        end
                    end
                    DROP: begin
                        if (is_tail) begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
